serial_word_assembler: RTL

Serial-in, parallel-out word assembler that sits downstream of the team's parallel-load shift register. It consumes the serial bit stream shifted out of that stage, one bit per qualified cycle. It rebuilds N-bit words in either bit order and presents each word on a valid/ready output port with a single-entry holding register. An optional even-parity bit per word is checked.

---
 rtl/serial_word_pkg.sv | 22 ++
 rtl/sw_out_reg.sv | 57 +++++
 rtl/serial_word_assembler.sv | 121 ++++++++++++
 3 files changed

// File: rtl/serial_word_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_word_pkg
// Brief    : Shared state and parity-polarity definitions for the assembler.
// Revision : 1.0 - initial release
// ============================================================================
package serial_word_pkg;

   typedef enum logic [0:0] {
      COLLECT = 1'b0,
      PARITY  = 1'b1
   } sw_state_t;

   typedef enum logic [0:0] {
      EVEN = 1'b0,
      ODD  = 1'b1
   } parity_pol_t;

   localparam parity_pol_t c_PARITY_POL = EVEN;

endpackage
`default_nettype wire

// File: rtl/sw_out_reg.sv
`default_nettype none
// ============================================================================
// Module   : sw_out_reg
// Brief    : Single-entry valid/ready holding register with overflow pulse.
// Revision : 1.0 - initial release
// ============================================================================
module sw_out_reg
   import serial_word_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [N-1:0] word_in,
   input  logic         perr_in,
   input  logic         word_ready,
   output logic [N-1:0] word_out,
   output logic         word_valid,
   output logic         parity_err,
   output logic         overflow
);

   logic [N-1:0] r_word;
   logic         r_valid;
   logic         r_perr;
   logic         r_ovf;
   logic         w_free;

   // The slot can take a new word if empty or being drained this same cycle.
   assign w_free = ~r_valid | word_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_word  <= '0;
         r_valid <= 1'b0;
         r_perr  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_ovf <= load & ~w_free;
         if (load && w_free) begin
            r_word  <= word_in;
            r_perr  <= perr_in;
            r_valid <= 1'b1;
         end else if (r_valid && word_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign word_out   = r_word;
   assign word_valid = r_valid;
   assign parity_err = r_perr;
   assign overflow   = r_ovf;

endmodule
`default_nettype wire

// File: rtl/serial_word_assembler.sv
`default_nettype none
// ============================================================================
// Module   : serial_word_assembler
// Brief    : Serial-in word assembler (either bit order) with a valid/ready
//            holding register. Define PARITY_CHECK_EN for per-word even parity.
// Revision : 1.0 - initial release
// ============================================================================
module serial_word_assembler
   import serial_word_pkg::*;
#(
   parameter int N = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   bit_in,
   input  logic                   bit_valid,
   input  logic                   msb_first,
   output logic [N-1:0]           word_out,
   output logic                   word_valid,
   input  logic                   word_ready,
   output logic                   overflow,
   output logic                   parity_err,
   output logic [$clog2(N+1)-1:0] bit_cnt
);

   localparam int                c_CNT_W = $clog2(N+1);
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(N-1);

   sw_state_t          r_state, w_state_nxt;
   logic [N-1:0]       r_asm, w_asm_nxt, w_shifted, w_word;
   logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic               r_msb, w_msb_nxt, w_order;
   logic               w_done, w_perr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= COLLECT;
         r_asm   <= '0;
         r_cnt   <= '0;
         r_msb   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_asm   <= w_asm_nxt;
         r_cnt   <= w_cnt_nxt;
         r_msb   <= w_msb_nxt;
      end
   end

   always_comb begin
      // Bit order is sampled only on the first bit of a word.
      w_order     = (r_cnt == '0) ? msb_first : r_msb;
      w_shifted   = w_order ? {r_asm[N-2:0], bit_in} : {bit_in, r_asm[N-1:1]};
      w_state_nxt = r_state;
      w_asm_nxt   = r_asm;
      w_cnt_nxt   = r_cnt;
      w_msb_nxt   = r_msb;
      w_done      = 1'b0;
      w_word      = r_asm;
      w_perr      = 1'b0;
      if (flush) begin
         w_state_nxt = COLLECT;
         w_asm_nxt   = '0;
         w_cnt_nxt   = '0;
      end else if (bit_valid) begin
         case (r_state)
            COLLECT: begin
               w_asm_nxt = w_shifted;
               w_msb_nxt = w_order;
               if (r_cnt == c_LAST) begin
`ifdef PARITY_CHECK_EN
                  w_cnt_nxt   = c_CNT_W'(N);
                  w_state_nxt = PARITY;
`else
                  w_done    = 1'b1;
                  w_word    = w_shifted;
                  w_asm_nxt = '0;
                  w_cnt_nxt = '0;
`endif
               end else begin
                  w_cnt_nxt = r_cnt + c_CNT_W'(1);
               end
            end
`ifdef PARITY_CHECK_EN
            PARITY: begin
               w_done      = 1'b1;
               w_word      = r_asm;
               w_perr      = (^r_asm) ^ bit_in ^ (c_PARITY_POL == ODD);
               w_asm_nxt   = '0;
               w_cnt_nxt   = '0;
               w_state_nxt = COLLECT;
            end
`endif
            default: begin
               w_state_nxt = COLLECT;
               w_asm_nxt   = '0;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   assign bit_cnt = r_cnt;

   sw_out_reg #(
      .N (N)
   ) u_out_reg (
      .clk        (clk),
      .rst        (rst),
      .load       (w_done),
      .word_in    (w_word),
      .perr_in    (w_perr),
      .word_ready (word_ready),
      .word_out   (word_out),
      .word_valid (word_valid),
      .parity_err (parity_err),
      .overflow   (overflow)
   );

endmodule
`default_nettype wire
